// File: rtl/alu_mdu.sv
// Execute-stage arithmetic unit: single-cycle ALU plus a multi-cycle multiply/divide unit that
// owns HI/LO. MD operands are latched at launch; the result is derived from the latched set and
// written to HI/LO on the final busy cycle edge.
module alu_mdu #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             start,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  // op[1:0] of the launched MD op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
  logic [1:0]        mdop_q, mdop_d;

  logic [WIDTH-1:0]  md_hi, md_lo;
  logic              md_wr;

  logic [2*WIDTH-1:0] prod;
  logic               div_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   num, den, uq, ur;

  // MD result from the latched operands; md_wr is low on divide by zero
  always_comb begin
    prod       = '0;
    div_signed = 1'b0;
    a_neg      = 1'b0;
    b_neg      = 1'b0;
    num        = '0;
    den        = '0;
    uq         = '0;
    ur         = '0;
    md_hi      = '0;
    md_lo      = '0;
    md_wr      = 1'b1;
    if (!mdop_q[1]) begin
      // Sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of the product are exact.
      if (!mdop_q[0]) begin
        prod = {{WIDTH{opa_q[WIDTH-1]}}, opa_q} * {{WIDTH{opb_q[WIDTH-1]}}, opb_q};
      end else begin
        prod = {{WIDTH{1'b0}}, opa_q} * {{WIDTH{1'b0}}, opb_q};
      end
      md_hi = prod[2*WIDTH-1:WIDTH];
      md_lo = prod[WIDTH-1:0];
    end else begin
      // Signed divide runs on magnitudes; most-negative / -1 falls out as quotient 0x80..0.
      div_signed = ~mdop_q[0];
      a_neg      = div_signed & opa_q[WIDTH-1];
      b_neg      = div_signed & opb_q[WIDTH-1];
      num        = a_neg ? (~opa_q + 1'b1) : opa_q;
      den        = b_neg ? (~opb_q + 1'b1) : opb_q;
      if (opb_q == '0) begin
        md_wr = 1'b0;
        den   = {{(WIDTH-1){1'b0}}, 1'b1};
      end
      uq    = num / den;
      ur    = num % den;
      md_lo = (a_neg ^ b_neg) ? (~uq + 1'b1) : uq;
      md_hi = a_neg ? (~ur + 1'b1) : ur;
    end
  end

  // FSM next-state: launch/MTHI/MTLO in idle, countdown and writeback in run
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    mdop_d  = mdop_q;
    unique case (state_q)
      StIdle: begin
        if (start && op[3]) begin
          if (!op[2]) begin
            opa_d   = a;
            opb_d   = b;
            mdop_d  = op[1:0];
            cnt_d   = op[1] ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
            state_d = StRun;
          end else if (op[1:0] == 2'b00) begin
            hi_d = a;
          end else if (op[1:0] == 2'b01) begin
            lo_d = a;
          end
        end
      end
      StRun: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          if (md_wr) begin
            hi_d = md_hi;
            lo_d = md_lo;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; latched operands need no reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
    opa_q  <= opa_d;
    opb_q  <= opb_d;
    mdop_q <= mdop_d;
  end

  // Combinational result mux
  always_comb begin
    res = '0;
    unique case (op)
      4'b0000: res = a + b;
      4'b0001: res = a - b;
      4'b0010: res = a | b;
      4'b0011: res = a & b;
      4'b0100: res = a ^ b;
      4'b0101: res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b0110: res = {{(WIDTH-1){1'b0}}, (a < b)};
      4'b0111: res = b << (WIDTH / 2);
      4'b1110: res = hi_q;
      4'b1111: res = lo_q;
      default: res = '0;
    endcase
  end

  assign zero = (res == '0);
  assign busy = (state_q == StRun);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Randomised bench for alu_mdu against a cycle-level behavioural model built from 64-bit
// arithmetic, plus the directed scenarios for ALU, MD timing, busy-ignore and reset.
module tb_alu_mdu;

  localparam int unsigned W  = 32;
  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a, b;
  logic [3:0]   op;
  logic         start;
  logic [W-1:0] res, hi, lo;
  logic         zero, busy;

  int total = 0;
  int bad   = 0;

  // Model state
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  logic         p_wr;
  int           m_left;

  alu_mdu #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .op    (op),
    .start (start),
    .res   (res),
    .zero  (zero),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_res(input logic [3:0] o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      4'd0:  return x + y;
      4'd1:  return x - y;
      4'd2:  return x | y;
      4'd3:  return x & y;
      4'd4:  return x ^ y;
      4'd5:  return (sx < sy) ? 1 : 0;
      4'd6:  return ({32'd0, x} < {32'd0, y}) ? 1 : 0;
      4'd7:  return y * 32'h0001_0000;
      4'd14: return m_hi;
      4'd15: return m_lo;
      default: return '0;
    endcase
  endfunction

  // Launch-time arithmetic from the rules with wide integers
  task automatic md_compute(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint    sx, sy, q, r;
    logic [63:0] p;
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    p_wr = 1'b1;
    case (o[1:0])
      2'd0: p = sx * sy;
      2'd1: p = {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 0) p_wr = 1'b0;
        else begin q = sx / sy; r = sx % sy; p = {r[31:0], q[31:0]}; end
      end
      default: begin
        if (y == 0) p_wr = 1'b0;
        else p = {x % y, x / y};
      end
    endcase
    p_hi = p[63:32];
    p_lo = p[31:0];
  endtask

  // Advance one clock: model update on the same inputs the DUT sees, then compare
  task automatic tick();
    if (reset) begin
      m_hi = '0; m_lo = '0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && p_wr) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (start && op[3]) begin
      if (!op[2]) begin
        md_compute(op, a, b);
        m_left = op[1] ? DC : MC;
      end else if (op == 4'd12) m_hi = a;
      else if (op == 4'd13) m_lo = a;
    end
    @(posedge clk);
    #1;
    check("busy", 64'(busy), 64'(m_left > 0));
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
    check("res", 64'(res), 64'(ref_res(op, a, b)));
    check("zero", 64'(zero), 64'(ref_res(op, a, b) == 0));
  endtask

  task automatic drive(input logic r, input logic [3:0] o, input logic s,
                       input logic [W-1:0] x, input logic [W-1:0] y);
    reset = r; op = o; start = s; a = x; b = y;
  endtask

  // Count busy cycles until idle, bounded
  task automatic run_out(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      n++;
      tick();
    end
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return W'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  int n;

  initial begin
    m_hi = '0; m_lo = '0; m_left = 0; p_wr = 1'b0; p_hi = '0; p_lo = '0;
    drive(1'b1, 4'd0, 1'b0, '0, '0);
    tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);

    // ALU ops
    drive(1'b0, 4'd0, 1'b1, 32'h7FFF_FFFF, 32'd1); #1;
    check("add", 64'(res), 64'h8000_0000);
    check("add_zero", 64'(zero), 64'd0);
    drive(1'b0, 4'd1, 1'b0, 32'd5, 32'd5); #1;
    check("sub", 64'(res), 64'd0);
    check("sub_zero", 64'(zero), 64'd1);
    drive(1'b0, 4'd5, 1'b0, 32'hFFFF_FFFF, 32'd1); #1;
    check("slt", 64'(res), 64'd1);
    drive(1'b0, 4'd6, 1'b0, 32'hFFFF_FFFF, 32'd1); #1;
    check("sltu", 64'(res), 64'd0);
    drive(1'b0, 4'd7, 1'b0, 32'd0, 32'h1234); #1;
    check("lui", 64'(res), 64'h1234_0000);
    tick();

    // MULT / MULTU
    drive(1'b0, 4'd8, 1'b1, 32'hFFFF_FFFD, 32'd5); tick();
    drive(1'b0, 4'd15, 1'b0, '0, '0); run_out(n);
    check("mult_cycles", 64'(n), 64'(MC));
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFF1);
    drive(1'b0, 4'd9, 1'b1, 32'hFFFF_FFFF, 32'd2); tick();
    drive(1'b0, 4'd0, 1'b0, '0, '0); run_out(n);
    check("multu_hi", 64'(hi), 64'd1);
    check("multu_lo", 64'(lo), 64'hFFFF_FFFE);

    // DIV / DIVU / divide by zero
    drive(1'b0, 4'd10, 1'b1, 32'hFFFF_FFF9, 32'd2); tick();
    drive(1'b0, 4'd0, 1'b0, '0, '0); run_out(n);
    check("div_cycles", 64'(n), 64'(DC));
    check("div_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(hi), 64'hFFFF_FFFF);
    drive(1'b0, 4'd11, 1'b1, 32'd7, 32'd2); tick();
    drive(1'b0, 4'd0, 1'b0, '0, '0); run_out(n);
    check("divu_lo", 64'(lo), 64'd3);
    check("divu_hi", 64'(hi), 64'd1);
    drive(1'b0, 4'd12, 1'b1, 32'hAA, 32'd0); tick();
    drive(1'b0, 4'd13, 1'b1, 32'hBB, 32'd0); tick();
    drive(1'b0, 4'd10, 1'b1, 32'd77, 32'd0); tick();
    drive(1'b0, 4'd0, 1'b0, '0, '0); run_out(n);
    check("div0_cycles", 64'(n), 64'(DC));
    check("div0_hi", 64'(hi), 64'hAA);
    check("div0_lo", 64'(lo), 64'hBB);

    // Starts while busy are ignored; MFLO returns stale lo
    drive(1'b0, 4'd8, 1'b1, 32'd6, 32'd7); tick();
    drive(1'b0, 4'd10, 1'b1, 32'd9, 32'd3); tick();
    drive(1'b0, 4'd12, 1'b1, 32'h55, 32'd0); tick();
    drive(1'b0, 4'd15, 1'b0, 32'd1, 32'd1); #1;
    check("mflo_busy", 64'(res), 64'hBB);
    run_out(n);
    check("ign_hi", 64'(hi), 64'd0);
    check("ign_lo", 64'(lo), 64'd42);

    // Reset mid-DIV discards the result; following MULT completes
    drive(1'b0, 4'd10, 1'b1, 32'd100, 32'd7); tick();
    drive(1'b0, 4'd0, 1'b0, '0, '0); tick(); tick(); tick();
    drive(1'b1, 4'd0, 1'b0, '0, '0); tick();
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_lo", 64'(lo), 64'd0);
    drive(1'b0, 4'd0, 1'b0, '0, '0);
    for (int i = 0; i < 12; i++) tick();
    check("no_late_wr", 64'(lo), 64'd0);
    drive(1'b0, 4'd9, 1'b1, 32'd3, 32'd4); tick();
    drive(1'b0, 4'd0, 1'b0, '0, '0); run_out(n);
    check("mult_after_rst", 64'(lo), 64'd12);

    // MTLO while idle
    drive(1'b0, 4'd13, 1'b1, 32'h1234, 32'd0); tick();
    check("mtlo_busy", 64'(busy), 64'd0);
    drive(1'b0, 4'd15, 1'b0, '0, '0); #1;
    check("mflo", 64'(res), 64'h1234);
    check("mflo_zero", 64'(zero), 64'd0);
    tick();

    // Random traffic, including back-to-back launches and occasional reset
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 2) != 0), rnd_operand(), rnd_operand());
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
